// File: rtl/flip_invert_sequencer_if.sv
// RAM-side bus of the flip/invert sequencer: two combinational read ports and
// two write ports of the 2R/2W frame RAM.
// master = sequencer, slave = RAM.
interface flip_invert_sequencer_if #(
    parameter int AW = 17,
    parameter int DW = 32
);
    logic [AW-1:0] rd0_addr;
    logic [AW-1:0] rd1_addr;
    logic [DW-1:0] rd0_data;
    logic [DW-1:0] rd1_data;
    logic          wr0_en;
    logic [AW-1:0] wr0_addr;
    logic [DW-1:0] wr0_data;
    logic          wr1_en;
    logic [AW-1:0] wr1_addr;
    logic [DW-1:0] wr1_data;

    modport master (
        output rd0_addr, rd1_addr,
        input  rd0_data, rd1_data,
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data
    );

    modport slave (
        input  rd0_addr, rd1_addr,
        output rd0_data, rd1_data,
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data
    );
endinterface

// File: rtl/flip_invert_sequencer.sv
// Flip-horizontal + colour-invert sequencer for a 2R/2W frame RAM.
// Each row is processed as mirrored pixel pairs (left, right): one READ cycle
// latches both pixels, one WRITE cycle stores them swapped and XOR-ed with
// INV_MASK. An odd-width row's middle pixel is written once, through port 0.
// Optional feature: define FLIP_INVERT_CYCLE_COUNT_EN to add a 32-bit
// cycle_count output counting the busy cycles of the last frame.
module flip_invert_sequencer #(
    parameter int            WIDTH    = 320,
    parameter int            HEIGHT   = 240,
    parameter int            AW       = 17,
    parameter int            DW       = 32,
    parameter int            BASE     = 0,
    parameter logic [DW-1:0] INV_MASK = DW'(32'h00FF_FFFF)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
    output logic [31:0]             cycle_count,
`endif
    flip_invert_sequencer_if.master ram
);

    localparam int PAIRS = (WIDTH + 1) / 2;
    localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [AW-1:0] BASE_A   = AW'(BASE);
    localparam logic [AW-1:0] WIDTH_A  = AW'(WIDTH);
    localparam logic [AW-1:0] WLAST_A  = AW'(WIDTH - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(PAIRS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] rd0_addr_q, rd0_addr_d;
    logic [AW-1:0] rd1_addr_q, rd1_addr_d;
    logic          wr0_en_q, wr0_en_d;
    logic [AW-1:0] wr0_addr_q, wr0_addr_d;
    logic [DW-1:0] wr0_data_q, wr0_data_d;
    logic          wr1_en_q, wr1_en_d;
    logic [AW-1:0] wr1_addr_q, wr1_addr_d;
    logic [DW-1:0] wr1_data_q, wr1_data_d;

    // The pair collapses onto one pixel only for the middle of an odd row.
    logic          middle;
    logic [AW-1:0] next_row_base;
    assign middle        = (rd0_addr_q == rd1_addr_q);
    assign next_row_base = row_base_q + WIDTH_A;

    // Next-state and registered-output logic; write data is captured straight
    // from the read ports at the end of READ, so the write registers double
    // as the L/R capture registers.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd0_addr_d = rd0_addr_q;
        rd1_addr_d = rd1_addr_q;
        wr0_en_d   = 1'b0;
        wr0_addr_d = wr0_addr_q;
        wr0_data_d = wr0_data_q;
        wr1_en_d   = 1'b0;
        wr1_addr_d = wr1_addr_q;
        wr1_data_d = wr1_data_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d    = S_READ;
                    row_d      = '0;
                    col_d      = '0;
                    row_base_d = BASE_A;
                    rd0_addr_d = BASE_A;
                    rd1_addr_d = BASE_A + WLAST_A;
                    busy_d     = 1'b1;
                end
            end
            S_READ: begin
                state_d    = S_WRITE;
                wr0_en_d   = 1'b1;
                wr0_addr_d = rd0_addr_q;
                wr0_data_d = (middle ? ram.rd0_data : ram.rd1_data) ^ INV_MASK;
                wr1_en_d   = !middle;
                wr1_addr_d = rd1_addr_q;
                wr1_data_d = ram.rd0_data ^ INV_MASK;
            end
            S_WRITE: begin
                if (col_q != COL_LAST) begin
                    state_d    = S_READ;
                    col_d      = col_q + CW'(1);
                    rd0_addr_d = rd0_addr_q + AW'(1);
                    rd1_addr_d = rd1_addr_q - AW'(1);
                end else if (row_q == ROW_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = S_READ;
                    col_d      = '0;
                    row_d      = row_q + RW'(1);
                    row_base_d = next_row_base;
                    rd0_addr_d = next_row_base;
                    rd1_addr_d = next_row_base + WLAST_A;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd0_addr_q <= '0;
            rd1_addr_q <= '0;
            wr0_en_q   <= 1'b0;
            wr0_addr_q <= '0;
            wr0_data_q <= '0;
            wr1_en_q   <= 1'b0;
            wr1_addr_q <= '0;
            wr1_data_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd0_addr_q <= rd0_addr_d;
            rd1_addr_q <= rd1_addr_d;
            wr0_en_q   <= wr0_en_d;
            wr0_addr_q <= wr0_addr_d;
            wr0_data_q <= wr0_data_d;
            wr1_en_q   <= wr1_en_d;
            wr1_addr_q <= wr1_addr_d;
            wr1_data_q <= wr1_data_d;
        end
    end

`ifdef FLIP_INVERT_CYCLE_COUNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;

    // Busy-cycle counter: cleared on accept, frozen once the frame ends.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (state_q == S_IDLE && start) begin
            cycle_count_d = '0;
        end else if (busy_q) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign ram.rd0_addr = rd0_addr_q;
    assign ram.rd1_addr = rd1_addr_q;
    assign ram.wr0_en   = wr0_en_q;
    assign ram.wr0_addr = wr0_addr_q;
    assign ram.wr0_data = wr0_data_q;
    assign ram.wr1_en   = wr1_en_q;
    assign ram.wr1_addr = wr1_addr_q;
    assign ram.wr1_data = wr1_data_q;

endmodule

// File: tb/tb_flip_invert_sequencer.sv
// Bench for flip_invert_sequencer: four small instances with their own RAM
// models (4x2, 3x1, 7x5 wrapping a 64-word RAM, 1x3).
module tb_flip_invert_sequencer;

    localparam logic [31:0] M = 32'h00FF_FFFF;
    localparam int BASE_C = 40;
    localparam int W_C    = 7;
    localparam int H_C    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic start_a, start_b, start_c, start_d;
    logic busy_a, busy_b, busy_c, busy_d;
    logic done_a, done_b, done_c, done_d;
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
    logic [31:0] cc_a, cc_b, cc_c, cc_d;
`endif

    flip_invert_sequencer_if #(.AW(8), .DW(32)) if_a ();
    flip_invert_sequencer_if #(.AW(8), .DW(32)) if_b ();
    flip_invert_sequencer_if #(.AW(6), .DW(32)) if_c ();
    flip_invert_sequencer_if #(.AW(8), .DW(32)) if_d ();

    flip_invert_sequencer #(.WIDTH(4), .HEIGHT(2), .AW(8), .DW(32), .BASE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a),
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
        .cycle_count(cc_a),
`endif
        .ram(if_a));
    flip_invert_sequencer #(.WIDTH(3), .HEIGHT(1), .AW(8), .DW(32), .BASE(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
        .cycle_count(cc_b),
`endif
        .ram(if_b));
    flip_invert_sequencer #(.WIDTH(W_C), .HEIGHT(H_C), .AW(6), .DW(32), .BASE(BASE_C)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_c), .busy(busy_c), .done(done_c),
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
        .cycle_count(cc_c),
`endif
        .ram(if_c));
    flip_invert_sequencer #(.WIDTH(1), .HEIGHT(3), .AW(8), .DW(32), .BASE(0)) dut_d (
        .clk(clk), .reset_n(reset_n), .start(start_d), .busy(busy_d), .done(done_d),
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
        .cycle_count(cc_d),
`endif
        .ram(if_d));

    // RAM models: combinational reads, writes at the clock edge, plus write and
    // same-address-collision counters.
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] mem_c [0:63];
    logic [31:0] mem_d [0:255];
    int wcnt_a = 0, wcnt_b = 0, wcnt_c = 0, wcnt_d = 0;
    int dup_a = 0, dup_b = 0, dup_c = 0, dup_d = 0;

    assign if_a.rd0_data = mem_a[if_a.rd0_addr];
    assign if_a.rd1_data = mem_a[if_a.rd1_addr];
    assign if_b.rd0_data = mem_b[if_b.rd0_addr];
    assign if_b.rd1_data = mem_b[if_b.rd1_addr];
    assign if_c.rd0_data = mem_c[if_c.rd0_addr];
    assign if_c.rd1_data = mem_c[if_c.rd1_addr];
    assign if_d.rd0_data = mem_d[if_d.rd0_addr];
    assign if_d.rd1_data = mem_d[if_d.rd1_addr];

    always @(posedge clk) begin
        if (if_a.wr0_en) begin mem_a[if_a.wr0_addr] = if_a.wr0_data; wcnt_a++; end
        if (if_a.wr1_en) begin mem_a[if_a.wr1_addr] = if_a.wr1_data; wcnt_a++; end
        if (if_a.wr0_en && if_a.wr1_en && if_a.wr0_addr == if_a.wr1_addr) dup_a++;
        if (if_b.wr0_en) begin mem_b[if_b.wr0_addr] = if_b.wr0_data; wcnt_b++; end
        if (if_b.wr1_en) begin mem_b[if_b.wr1_addr] = if_b.wr1_data; wcnt_b++; end
        if (if_b.wr0_en && if_b.wr1_en && if_b.wr0_addr == if_b.wr1_addr) dup_b++;
        if (if_c.wr0_en) begin mem_c[if_c.wr0_addr] = if_c.wr0_data; wcnt_c++; end
        if (if_c.wr1_en) begin mem_c[if_c.wr1_addr] = if_c.wr1_data; wcnt_c++; end
        if (if_c.wr0_en && if_c.wr1_en && if_c.wr0_addr == if_c.wr1_addr) dup_c++;
        if (if_d.wr0_en) begin mem_d[if_d.wr0_addr] = if_d.wr0_data; wcnt_d++; end
        if (if_d.wr1_en) begin mem_d[if_d.wr1_addr] = if_d.wr1_data; wcnt_d++; end
        if (if_d.wr0_en && if_d.wr1_en && if_d.wr0_addr == if_d.wr1_addr) dup_d++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Per-cycle expectations for the 4x2 frame (cycle 1 = first after accept).
    typedef struct {
        int start; int busy; int done;
        int e0; int a0; int e1; int a1;
        int rd0; int rd1;
    } vec_t;
    vec_t tbl [10];

    // Reference model for instance C: mirror each row of a snapshot and invert.
    logic [31:0] orig_c [0:63];
    logic [31:0] exp_c  [0:63];

    task automatic model_c();
        exp_c = orig_c;
        for (int r = 0; r < H_C; r++)
            for (int c = 0; c < W_C; c++)
                exp_c[(BASE_C + r * W_C + c) % 64] =
                    orig_c[(BASE_C + r * W_C + (W_C - 1 - c)) % 64] ^ M;
    endtask

    task automatic run_c(input bit noisy, output int done_cyc);
        int  cyc;
        bit  got;
        cyc = 0;
        got = 1'b0;
        start_c = 1'b1;
        while (cyc < 200 && !got) begin
            step();
            cyc++;
            if (done_c === 1'b1) got = 1'b1;
            else if (noisy) start_c = (cyc == 9) ? 1'b1 : ($urandom_range(0, 3) == 0);
            else start_c = 1'b0;
        end
        start_c = 1'b0;
        done_cyc = got ? cyc : -1;
    endtask

    task automatic frame_c(input bit noisy, input string tag);
        int dc;
        int w0;
        orig_c = mem_c;
        model_c();
        w0 = wcnt_c;
        run_c(noisy, dc);
        chk({tag, "_done_cycle"}, 64'(dc), 64'(2 * H_C * ((W_C + 1) / 2) + 1));
        step();
        chk({tag, "_busy_after"}, 64'(busy_c), 64'(0));
        chk({tag, "_done_after"}, 64'(done_c), 64'(0));
        chk({tag, "_writes"}, 64'(wcnt_c - w0), 64'(W_C * H_C));
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
        chk({tag, "_cycle_count"}, 64'(cc_c), 64'(2 * H_C * ((W_C + 1) / 2) + 1));
`endif
        for (int i = 0; i < 64; i++)
            chk($sformatf("%s_mem[%0d]", tag, i), 64'(mem_c[i]), 64'(exp_c[i]));
        $display("[TB] frame %s: done at cycle %0d", tag, dc);
    endtask

    task automatic wait_done_a(input int cyc0, output int cyc);
        bit got;
        cyc = cyc0;
        got = 1'b0;
        while (cyc < 100 && !got) begin
            step();
            cyc++;
            if (done_a === 1'b1) got = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        bit got;
        int w0;
        logic [31:0] pa, pb, pc;
        logic [31:0] orig_d [0:2];

        tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0, 3};
        tbl[1] = '{0, 1, 0, 1, 0, 1, 3, 0, 3};
        tbl[2] = '{0, 1, 0, 0, 0, 0, 0, 1, 2};
        tbl[3] = '{1, 1, 0, 1, 1, 1, 2, 1, 2};
        tbl[4] = '{0, 1, 0, 0, 0, 0, 0, 4, 7};
        tbl[5] = '{0, 1, 0, 1, 4, 1, 7, 4, 7};
        tbl[6] = '{1, 1, 0, 0, 0, 0, 0, 5, 6};
        tbl[7] = '{0, 1, 0, 1, 5, 1, 6, 5, 6};
        tbl[8] = '{0, 1, 1, 0, 0, 0, 0, 5, 6};
        tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 5, 6};

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = (i < 8) ? 32'(i) : 32'd0;
            mem_b[i] = 32'd0;
            mem_d[i] = 32'd0;
        end
        for (int i = 0; i < 64; i++) mem_c[i] = $urandom;

        reset_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
        step();
        step();
        chk("rst_busy", 64'(busy_a), 64'(0));
        chk("rst_done", 64'(done_a), 64'(0));
        chk("rst_wr0_en", 64'(if_a.wr0_en), 64'(0));
        chk("rst_wr1_en", 64'(if_a.wr1_en), 64'(0));
        chk("rst_rd1_addr", 64'(if_a.rd1_addr), 64'(0));
        chk("rst_wr0_data", 64'(if_a.wr0_data), 64'(0));
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
        chk("rst_cycle_count", 64'(cc_a), 64'(0));
`endif
        reset_n = 1'b1;
        step();

        // 4x2 frame, cycle by cycle, with ignored start pulses while busy.
        for (int i = 0; i < 10; i++) begin
            start_a = (tbl[i].start != 0);
            step();
            chk($sformatf("a_busy[%0d]", i + 1), 64'(busy_a), 64'(tbl[i].busy));
            chk($sformatf("a_done[%0d]", i + 1), 64'(done_a), 64'(tbl[i].done));
            chk($sformatf("a_wr0_en[%0d]", i + 1), 64'(if_a.wr0_en), 64'(tbl[i].e0));
            chk($sformatf("a_wr1_en[%0d]", i + 1), 64'(if_a.wr1_en), 64'(tbl[i].e1));
            if (tbl[i].e0 != 0)
                chk($sformatf("a_wr0_addr[%0d]", i + 1), 64'(if_a.wr0_addr), 64'(tbl[i].a0));
            if (tbl[i].e1 != 0)
                chk($sformatf("a_wr1_addr[%0d]", i + 1), 64'(if_a.wr1_addr), 64'(tbl[i].a1));
            chk($sformatf("a_rd0_addr[%0d]", i + 1), 64'(if_a.rd0_addr), 64'(tbl[i].rd0));
            chk($sformatf("a_rd1_addr[%0d]", i + 1), 64'(if_a.rd1_addr), 64'(tbl[i].rd1));
        end
        start_a = 1'b0;
        chk("a_ram0_literal", 64'(mem_a[0]), 64'(32'h00FF_FFFC));
        for (int i = 0; i < 8; i++)
            chk($sformatf("a_ram[%0d]", i), 64'(mem_a[i]), 64'(32'((i / 4) * 4 + 3 - (i % 4)) ^ M));
        chk("a_writes", 64'(wcnt_a), 64'(8));
        $display("[TB] frame a1: 4x2 table sequence complete");

        // Start held high through DONE: second frame, then immediate restart.
        start_a = 1'b1;
        step();
        wait_done_a(1, cyc);
        chk("a2_done_cycle", 64'(cyc), 64'(9));
        step();
        chk("a2_idle_busy", 64'(busy_a), 64'(0));
        chk("a2_idle_done", 64'(done_a), 64'(0));
        for (int i = 0; i < 8; i++)
            chk($sformatf("a2_ram[%0d]", i), 64'(mem_a[i]), 64'(i));
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
        chk("a2_cycle_count", 64'(cc_a), 64'(9));
`endif
        $display("[TB] frame a2: done at cycle %0d", cyc);
        step();
        chk("a3_restart_busy", 64'(busy_a), 64'(1));
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
        chk("a3_cycle_count_clear", 64'(cc_a), 64'(0));
`endif
        start_a = 1'b0;
        wait_done_a(1, cyc);
        chk("a3_done_cycle", 64'(cyc), 64'(9));
        step();
        chk("a3_done_once", 64'(done_a), 64'(0));
        step();
        step();
        chk("a3_ram0", 64'(mem_a[0]), 64'(32'h00FF_FFFC));
        chk("a_no_dup", 64'(dup_a), 64'(0));
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
        chk("a3_cycle_count_hold", 64'(cc_a), 64'(9));
`endif
        $display("[TB] frame a3: done at cycle %0d", cyc);

        // 3x1 frame: middle pixel written once through port 0.
        pa = 32'hA1B2_C3D4; pb = 32'h5566_7788; pc = 32'h0F1E_2D3C;
        mem_b[0] = pa; mem_b[1] = pb; mem_b[2] = pc;
        start_b = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (cyc < 50 && !got) begin
            step();
            cyc++;
            start_b = 1'b0;
            if (cyc == 2) begin
                chk("b_pair_wr0_addr", 64'(if_b.wr0_addr), 64'(0));
                chk("b_pair_wr1_en", 64'(if_b.wr1_en), 64'(1));
                chk("b_pair_wr1_addr", 64'(if_b.wr1_addr), 64'(2));
            end
            if (cyc == 4) begin
                chk("b_mid_wr0_en", 64'(if_b.wr0_en), 64'(1));
                chk("b_mid_wr1_en", 64'(if_b.wr1_en), 64'(0));
                chk("b_mid_wr0_addr", 64'(if_b.wr0_addr), 64'(1));
                chk("b_mid_wr0_data", 64'(if_b.wr0_data), 64'(pb ^ M));
            end
            if (done_b === 1'b1) got = 1'b1;
        end
        chk("b_done_cycle", 64'(cyc), 64'(5));
        step();
        chk("b_ram0", 64'(mem_b[0]), 64'(pc ^ M));
        chk("b_ram1", 64'(mem_b[1]), 64'(pb ^ M));
        chk("b_ram2", 64'(mem_b[2]), 64'(pa ^ M));
        chk("b_writes", 64'(wcnt_b), 64'(3));
        chk("b_no_dup", 64'(dup_b), 64'(0));
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
        chk("b_cycle_count", 64'(cc_b), 64'(5));
`endif
        $display("[TB] frame b: done at cycle %0d", cyc);

        // 1x3 frame: every pixel is a middle pixel.
        for (int i = 0; i < 3; i++) begin
            orig_d[i] = $urandom;
            mem_d[i] = orig_d[i];
        end
        start_d = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (cyc < 50 && !got) begin
            step();
            cyc++;
            start_d = 1'b0;
            if (done_d === 1'b1) got = 1'b1;
        end
        chk("d_done_cycle", 64'(cyc), 64'(7));
        step();
        for (int i = 0; i < 3; i++)
            chk($sformatf("d_ram[%0d]", i), 64'(mem_d[i]), 64'(orig_d[i] ^ M));
        chk("d_writes", 64'(wcnt_d), 64'(3));
`ifdef FLIP_INVERT_CYCLE_COUNT_EN
        chk("d_cycle_count", 64'(cc_d), 64'(7));
`endif
        $display("[TB] frame d: done at cycle %0d", cyc);

        // 7x5 frame wrapping a 64-word RAM: clean run, then one with stray starts.
        frame_c(1'b0, "c_clean");
        for (int i = 0; i < 64; i++) mem_c[i] = $urandom;
        frame_c(1'b1, "c_noisy");

        // Reset in row 2: outputs drop at once, no writes while held.
        for (int i = 0; i < 64; i++) mem_c[i] = $urandom;
        w0 = wcnt_c;
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        repeat (17) step();
        reset_n = 1'b0;
        #1;
        chk("c_rst_busy", 64'(busy_c), 64'(0));
        chk("c_rst_done", 64'(done_c), 64'(0));
        chk("c_rst_wr0_en", 64'(if_c.wr0_en), 64'(0));
        chk("c_rst_wr1_en", 64'(if_c.wr1_en), 64'(0));
        chk("c_rst_writes_before", 64'(wcnt_c - w0), 64'(2 * W_C));
        repeat (3) step();
        chk("c_rst_writes_held", 64'(wcnt_c - w0), 64'(2 * W_C));
        reset_n = 1'b1;
        step();
        $display("[TB] frame c_reset: aborted in row 2 after %0d writes", wcnt_c - w0);
        frame_c(1'b0, "c_after_reset");
        chk("c_no_dup", 64'(dup_c), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
